// File: rtl/elvm_pkg.sv
// ELVM core shared definitions.
// Opcodes, instruction field offsets, states, register names.
package elvm_pkg;

  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_PUTC  = 5'd5;
  localparam logic [4:0] OP_GETC  = 5'd6;
  localparam logic [4:0] OP_EXIT  = 5'd7;
  localparam logic [4:0] OP_EQ    = 5'd8;
  localparam logic [4:0] OP_GE    = 5'd13;
  localparam logic [4:0] OP_JEQ   = 5'd14;
  localparam logic [4:0] OP_JGE   = 5'd19;
  localparam logic [4:0] OP_JMP   = 5'd20;

  // Field offsets above the immediate (im occupies the low WORD_W bits)
  localparam int OP_OFS = 7;
  localparam int SI_OFS = 6;
  localparam int RD_OFS = 3;
  localparam int RS_OFS = 0;

  localparam logic [2:0] R_A  = 3'd0;
  localparam logic [2:0] R_B  = 3'd1;
  localparam logic [2:0] R_C  = 3'd2;
  localparam logic [2:0] R_D  = 3'd3;
  localparam logic [2:0] R_SP = 3'd4;
  localparam logic [2:0] R_BP = 3'd5;
  localparam int         NREGS = 6;

  typedef enum logic [1:0] {
    S_RUN,
    S_OUT_WAIT,
    S_IN_WAIT,
    S_HALT
  } state_e;

  // k: 0 eq, 1 ne, 2 lt, 3 gt, 4 le, 5 ge (unsigned)
  function automatic logic cmp_sel(
    input logic [2:0] k,
    input logic       eq,
    input logic       lt
  );
    logic r;
    r = 1'b0;
    case (k)
      3'd0:    r = eq;
      3'd1:    r = !eq;
      3'd2:    r = lt;
      3'd3:    r = !lt && !eq;
      3'd4:    r = lt || eq;
      3'd5:    r = !lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elvm_dmem.sv
// ELVM data memory.
// Sync write, async read, zero at power-up, untouched by reset.
module elvm_dmem
  import elvm_pkg::*;
#(
  parameter int WORD_W = 24,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

  // store port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/elvm_core.sv
// ELVM single-cycle core.
// One instruction per cycle; putc/getc stall on handshakes.
module elvm_core
  import elvm_pkg::*;
#(
  parameter int WORD_W     = 24,
  parameter int DMEM_DEPTH = 256,
  parameter int PC_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [WORD_W+11:0] imem_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              halted
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [2:0] R_LAST = R_BP;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        in_rd_q, in_rd_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              halted_q, halted_d;
  logic [WORD_W-1:0] regs_q [NREGS];

  logic [4:0]        op;
  logic              src_im;
  logic [2:0]        rd, rs;
  logic [WORD_W-1:0] im, rd_val, rs_val, src, dm_rdata, wb_val;
  logic              wb_en, dm_we, is_cmp, is_jcc;
  logic [2:0]        wb_idx;

  assign op     = imem_data[WORD_W+OP_OFS +: 5];
  assign src_im = imem_data[WORD_W+SI_OFS];
  assign rd     = imem_data[WORD_W+RD_OFS +: 3];
  assign rs     = imem_data[WORD_W+RS_OFS +: 3];
  assign im     = imem_data[WORD_W-1:0];

  assign rd_val = (rd <= R_LAST) ? regs_q[rd] : '0;
  assign rs_val = (rs <= R_LAST) ? regs_q[rs] : '0;
  assign src    = src_im ? im : rs_val;
  assign is_cmp = (op >= OP_EQ) && (op <= OP_GE);
  assign is_jcc = (op >= OP_JEQ) && (op <= OP_JGE);

  elvm_dmem #(
    .WORD_W(WORD_W),
    .DEPTH (DMEM_DEPTH)
  ) u_dmem (
    .clk    (clk),
    .we_i   (dm_we && !rst),
    .waddr_i(src[AW-1:0]),
    .wdata_i(rd_val),
    .raddr_i(src[AW-1:0]),
    .rdata_o(dm_rdata)
  );

  // execute / handshake next-state logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    in_rd_d     = in_rd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;
    wb_en       = 1'b0;
    wb_idx      = rd;
    wb_val      = src;
    dm_we       = 1'b0;
    unique case (state_q)
      S_RUN: begin
        pc_d = pc_q + PC_ONE;
        unique case (1'b1)
          (op == OP_MOV): wb_en = 1'b1;
          (op == OP_ADD): begin
            wb_en  = 1'b1;
            wb_val = rd_val + src;
          end
          (op == OP_SUB): begin
            wb_en  = 1'b1;
            wb_val = rd_val - src;
          end
          (op == OP_LOAD): begin
            wb_en  = 1'b1;
            wb_val = dm_rdata;
          end
          (op == OP_STORE): dm_we = 1'b1;
          (op == OP_PUTC): begin
            out_valid_d = 1'b1;
            out_data_d  = src[7:0];
            pc_d        = pc_q;
            state_d     = S_OUT_WAIT;
          end
          (op == OP_GETC): begin
            in_rd_d = rd;
            pc_d    = pc_q;
            state_d = S_IN_WAIT;
          end
          (op == OP_EXIT): begin
            halted_d = 1'b1;
            pc_d     = pc_q;
            state_d  = S_HALT;
          end
          is_cmp: begin
            wb_en  = 1'b1;
            wb_val = WORD_W'(cmp_sel(3'(op - OP_EQ),
                                     rd_val == src,
                                     rd_val < src));
          end
          is_jcc: begin
            if (cmp_sel(3'(op - OP_JEQ),
                        rd_val == rs_val,
                        rd_val < rs_val))
              pc_d = im[PC_W-1:0];
          end
          (op == OP_JMP): pc_d = im[PC_W-1:0];
          default: ;
        endcase
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_q + PC_ONE;
          state_d     = S_RUN;
        end
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          wb_en   = 1'b1;
          wb_idx  = in_rd_q;
          wb_val  = WORD_W'(in_data);
          pc_d    = pc_q + PC_ONE;
          state_d = S_RUN;
        end
      end
      S_HALT: ;
      default: ;
    endcase
  end

  // architectural state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= '0;
      in_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      in_rd_q     <= in_rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      halted_q    <= halted_d;
      if (wb_en && (wb_idx <= R_LAST)) regs_q[wb_idx] <= wb_val;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = (state_q == S_IN_WAIT);
  assign halted    = halted_q;

endmodule

// File: tb/tb_elvm_core.sv
// ELVM core bench: directed programs plus random programs,
// checked each cycle against an instruction-level interpreter.
module tb_elvm_core;

  localparam int WW = 24;
  localparam int IW = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   imem_addr;
  logic [IW-1:0] imem_data;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          in_ready;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          halted;

  logic [IW-1:0] imem [4096];
  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  elvm_core #(.WORD_W(24), .DMEM_DEPTH(256), .PC_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .in_valid (in_valid),
    .in_data  (in_data),
    .halted   (halted)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] bytes[$];

  logic [WW-1:0] m_reg [6];
  logic [WW-1:0] m_dmem [256];
  logic [11:0]   m_pc;
  logic          m_outv, m_inw, m_halt;
  logic [7:0]    m_outd;
  logic [2:0]    m_inrd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int op, input int si,
                                       input int rd, input int rs,
                                       input logic [WW-1:0] im);
    return {op[4:0], si[0], rd[2:0], rs[2:0], im};
  endfunction

  function automatic logic [WW-1:0] rv(input logic [2:0] i);
    return (i < 6) ? m_reg[i] : '0;
  endfunction

  function automatic bit rel(input int k, input logic [WW-1:0] a,
                             input logic [WW-1:0] b);
    case (k)
      0: return a == b;
      1: return a != b;
      2: return a < b;
      3: return a > b;
      4: return a <= b;
      5: return a >= b;
      default: return 0;
    endcase
  endfunction

  task automatic wr(input logic [2:0] i, input logic [WW-1:0] v);
    if (i < 6) m_reg[i] = v;
  endtask

  // one clock of the reference machine, using current inputs
  task automatic model_step();
    logic [IW-1:0] ins;
    int op;
    logic [2:0] rd, rs;
    logic [WW-1:0] im, src, a;
    logic [11:0] npc;
    if (rst) begin
      m_pc = 0; m_outv = 0; m_outd = 0; m_inw = 0; m_halt = 0; m_inrd = 0;
      for (int i = 0; i < 6; i++) m_reg[i] = 0;
      return;
    end
    if (m_halt) return;
    if (m_outv) begin
      if (out_ready) begin m_outv = 0; m_pc = m_pc + 1; end
      return;
    end
    if (m_inw) begin
      if (in_valid) begin
        wr(m_inrd, {16'h0, in_data}); m_inw = 0; m_pc = m_pc + 1;
      end
      return;
    end
    ins = imem[m_pc];
    op  = int'(ins[35:31]);
    rd  = ins[29:27];
    rs  = ins[26:24];
    im  = ins[23:0];
    a   = rv(rd);
    src = ins[30] ? im : rv(rs);
    npc = m_pc + 1;
    case (op)
      0: wr(rd, src);
      1: wr(rd, a + src);
      2: wr(rd, a - src);
      3: wr(rd, m_dmem[src % 256]);
      4: m_dmem[src % 256] = a;
      5: begin m_outv = 1; m_outd = src[7:0]; npc = m_pc; end
      6: begin m_inw = 1; m_inrd = rd; npc = m_pc; end
      7: begin m_halt = 1; npc = m_pc; end
      8, 9, 10, 11, 12, 13: wr(rd, rel(op - 8, a, src) ? 1 : 0);
      14, 15, 16, 17, 18, 19:
        if (rel(op - 14, a, rv(rs))) npc = im[11:0];
      20: npc = im[11:0];
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic tick();
    if (!rst && out_valid && out_ready) bytes.push_back(out_data);
    model_step();
    @(posedge clk);
    #1;
    chk("pc", 32'(imem_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(m_outv));
    chk("out_data", 32'(out_data), 32'(m_outd));
    chk("in_ready", 32'(in_ready), 32'(m_inw));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic do_reset();
    rst = 1; out_ready = 0; in_valid = 0; in_data = 0;
    tick(); tick();
    rst = 0;
    chk("rst_pc", 32'(imem_addr), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    bytes.delete();
  endtask

  task automatic run_to_halt();
    for (int k = 0; k < 60 && !halted; k++) tick();
    chk("halt_reached", 32'(halted), 1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = '0;
  endtask

  initial begin
    int hi;
    logic [11:0] pc_hold;
    for (int i = 0; i < 256; i++) m_dmem[i] = '0;
    rst = 1; out_ready = 0; in_valid = 0; in_data = 0;
    clear_imem();

    // arithmetic wrap
    imem[0] = mk(0, 1, 0, 0, 24'd5);
    imem[1] = mk(1, 1, 0, 0, 24'd3);
    imem[2] = mk(2, 1, 0, 0, 24'd10);
    imem[3] = mk(5, 0, 0, 0, 0);
    imem[4] = mk(8, 1, 0, 0, 24'hFFFFFE);
    imem[5] = mk(5, 0, 0, 0, 0);
    imem[6] = mk(7, 0, 0, 0, 0);
    do_reset();
    out_ready = 1;
    tick(); tick(); tick();
    chk("arith_pc3", 32'(imem_addr), 3);
    run_to_halt();
    chk("arith_nbytes", bytes.size(), 2);
    chk("arith_low", 32'(bytes[0]), 32'h FE);
    chk("arith_full", 32'(bytes[1]), 1);

    // putc with back-pressure
    clear_imem();
    imem[0] = mk(0, 1, 0, 0, 24'h41);
    imem[1] = mk(5, 0, 0, 0, 0);
    imem[2] = mk(7, 0, 0, 0, 0);
    do_reset();
    tick(); tick();
    hi = int'(out_valid);
    repeat (3) begin tick(); hi += int'(out_valid); end
    chk("putc_hold", hi, 4);
    chk("putc_data", 32'(out_data), 32'h41);
    chk("putc_pc_held", 32'(imem_addr), 1);
    out_ready = 1;
    tick();
    chk("putc_done", 32'(out_valid), 0);
    chk("putc_pc_adv", 32'(imem_addr), 2);
    chk("putc_xfers", bytes.size(), 1);
    chk("putc_byte", 32'(bytes[0]), 32'h41);
    run_to_halt();

    // getc with delayed input
    clear_imem();
    imem[0] = mk(6, 0, 1, 0, 0);
    imem[1] = mk(5, 0, 0, 1, 0);
    imem[2] = mk(8, 1, 1, 0, 24'h7A);
    imem[3] = mk(5, 0, 0, 1, 0);
    imem[4] = mk(7, 0, 0, 0, 0);
    do_reset();
    in_valid = 1; in_data = 8'h55;
    tick();
    in_valid = 0;
    hi = int'(in_ready);
    repeat (3) begin tick(); hi += int'(in_ready); end
    in_valid = 1; in_data = 8'h7A;
    tick();
    in_valid = 0; in_data = 8'hFF;
    chk("getc_wait", hi, 4);
    chk("getc_rdy_low", 32'(in_ready), 0);
    chk("getc_pc", 32'(imem_addr), 1);
    out_ready = 1;
    run_to_halt();
    chk("getc_nbytes", bytes.size(), 2);
    chk("getc_low", 32'(bytes[0]), 32'h7A);
    chk("getc_full", 32'(bytes[1]), 1);

    // dmem address wrap
    clear_imem();
    imem[0] = mk(0, 1, 0, 0, 24'd7);
    imem[1] = mk(4, 1, 0, 0, 24'h105);
    imem[2] = mk(3, 1, 2, 0, 24'd5);
    imem[3] = mk(5, 0, 0, 2, 0);
    imem[4] = mk(7, 0, 0, 0, 0);
    do_reset();
    out_ready = 1;
    run_to_halt();
    chk("wrap_nbytes", bytes.size(), 1);
    chk("wrap_load", 32'(bytes[0]), 7);

    // conditional jumps
    clear_imem();
    imem[0]     = mk(0, 1, 0, 0, 24'd2);
    imem[1]     = mk(0, 1, 1, 0, 24'd3);
    imem[2]     = mk(16, 0, 0, 1, 24'h020);
    imem[12'h20] = mk(19, 0, 0, 1, 24'h040);
    imem[12'h21] = mk(7, 0, 0, 0, 0);
    do_reset();
    tick(); tick(); tick();
    chk("jlt_taken", 32'(imem_addr), 32'h20);
    tick();
    chk("jge_not_taken", 32'(imem_addr), 32'h21);
    tick();
    chk("jmp_halt", 32'(halted), 1);

    // exit freeze
    clear_imem();
    imem[0] = mk(7, 0, 0, 0, 0);
    do_reset();
    tick();
    pc_hold = imem_addr;
    repeat (10) tick();
    chk("exit_halted", 32'(halted), 1);
    chk("exit_pc", 32'(imem_addr), 32'(pc_hold));

    // reset while a byte is pending
    clear_imem();
    imem[0] = mk(0, 1, 0, 0, 24'h41);
    imem[1] = mk(5, 0, 0, 0, 0);
    do_reset();
    tick(); tick(); tick();
    chk("pend_valid", 32'(out_valid), 1);
    rst = 1; out_ready = 1;
    tick();
    rst = 0; out_ready = 0;
    chk("pend_drop", 32'(out_valid), 0);
    chk("pend_pc", 32'(imem_addr), 0);

    // random programs
    for (int p = 0; p < 6; p++) begin
      clear_imem();
      for (int i = 0; i < 48; i++) begin
        int op;
        logic [WW-1:0] im;
        op = $urandom_range(0, 31);
        if (op == 7) op = 0;
        if ($urandom_range(0, 1) == 0)
          im = WW'($urandom_range(0, 47)) | (WW'($urandom) & 24'hFFF000);
        else
          im = WW'($urandom);
        imem[i] = mk(op, $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 7), im);
      end
      imem[48] = mk(20, 1, 0, 0, 0);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = ($urandom_range(0, 2) == 0);
        in_data   = 8'($urandom);
        rst       = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elvm_core.md
ELVM_CORE -- requirements
Module: elvm_core

Interface
REQ-001 Parameter WORD_W, 24, data-path and register width in bits (>= 8).
REQ-002 Parameter DMEM_DEPTH, 256, data-memory words (power of two).
REQ-003 Parameter PC_W, 12, program-counter width; instruction width INSTR_W = 12 + WORD_W.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  PC_W  current PC, driven directly from the PC register.
REQ-007 imem_data  input  INSTR_W  instruction at imem_addr, combinational in the same cycle.
REQ-008 out_valid  output  1  output byte pending.
REQ-009 out_data  output  8  byte for putc, stable while out_valid.
REQ-010 out_ready  input  1  sink accepts the byte when high together with out_valid.
REQ-011 in_ready  output  1  core waiting for a getc byte.
REQ-012 in_valid  input  1  in_data valid.
REQ-013 in_data  input  8  getc byte.
REQ-014 halted  output  1  exit executed.

Function
REQ-015 Instruction fields, MSB first: op[5], src_im[1], rd[3], rs[3], im[WORD_W].
REQ-016 Register file: 6 regs (0=A, 1=B, 2=C, 3=D, 4=SP, 5=BP); index 6/7 reads 0, writes are discarded.
REQ-017 SRC = im when src_im=1, else reg[rs]; applies to mov, add, sub, load, store, putc, eq..ge.
REQ-018 Ops: 0 mov rd<=SRC; 1 add rd<=rd+SRC; 2 sub rd<=rd-SRC; 3 load rd<=dmem[SRC]; 4 store dmem[SRC]<=rd; 5 putc; 6 getc; 7 exit.
REQ-019 Ops 8..13 eq, ne, lt, gt, le, ge: rd <= 1 if (rd OP SRC) else 0, unsigned.
REQ-020 Ops 14..19 jeq..jge: PC<=im[PC_W-1:0] if (reg[rd] OP reg[rs]) unsigned, else PC+1; op 20 jmp: PC<=im unconditionally.
REQ-021 Opcodes 21..31: no-op, PC+1.
REQ-022 Arithmetic wraps modulo 2^WORD_W; no flags.
REQ-023 DMEM address = SRC[log2(DMEM_DEPTH)-1:0]; higher bits ignored (wrap).
REQ-024 Store writes on the clock edge; load reads asynchronously, so every non-I/O instruction completes in 1 cycle.
REQ-025 PC increments modulo 2^PC_W.
REQ-026 States: RUN, OUT_WAIT, IN_WAIT, HALT.
REQ-027 RUN + putc: out_data <= SRC[7:0], out_valid <= 1, go to OUT_WAIT; PC holds.
REQ-028 OUT_WAIT: on out_valid & out_ready, out_valid <= 0, PC+1, go to RUN; putc occupies at least 2 cycles.
REQ-029 RUN + getc: go to IN_WAIT; in_ready = 1 only in IN_WAIT.
REQ-030 IN_WAIT: on in_valid, reg[rd] <= zero-extended in_data, PC+1, go to RUN; in_data is ignored outside IN_WAIT.
REQ-031 RUN + exit: go to HALT, halted <= 1; HALT is terminal until rst, with no PC, register or memory change.
REQ-032 While in OUT_WAIT, IN_WAIT or HALT, imem_data is ignored and no register or memory write occurs.

Reset
REQ-033 rst: PC=0, all registers 0, state RUN, out_valid=0, out_data=0, halted=0; rst overrides any other event in the same cycle.
REQ-034 rst asserted in OUT_WAIT or IN_WAIT drops the pending transfer; no byte is written.
REQ-035 DMEM is zero at power-up and is not cleared by rst.

Structure
REQ-036 Package elvm_pkg: opcode constants, field bit positions, state enum, register index constants.
REQ-037 Sub-module elvm_dmem: DMEM_DEPTH x WORD_W array, 1 sync write port, 1 async read port.

Verification
REQ-038 mov A,5; add A,3; sub A,10 (WORD_W=24) -> A=0xFFFFFE after 3 cycles.
REQ-039 mov A,0x41; putc A with out_ready low 4 cycles, then high -> out_data=0x41, out_valid held 4 cycles, exactly one transfer, PC advances once.
REQ-040 getc B, in_valid asserted after 3 idle cycles with in_data=0x7A -> B=0x00007A, in_ready high exactly during the wait.
REQ-041 mov A,7; store A,0x105; load C,5 (DMEM_DEPTH=256) -> C=7 (address wrap).
REQ-042 mov A,2; mov B,3; jlt A,B,0x020 -> PC=0x020; jge A,B,0x040 -> PC advances by 1.
REQ-043 exit then 10 cycles -> halted=1 and PC frozen; rst during OUT_WAIT -> out_valid=0 and PC=0 next cycle.
